// File: rtl/l2_mem_scheduler.sv
// rtl/l2_mem_scheduler.sv - L2 memory-port scheduler with coalescing write buffer
// Refill reads bypass buffered writebacks; matching reads are forwarded from the buffer.
module l2_mem_scheduler #(
  parameter int ADDR_W   = 32,
  parameter int LINE_W   = 128,
  parameter int OFF_W    = 4,
  parameter int WB_DEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      up_valid_i,
  input  logic                      up_rw_i,
  input  logic [ADDR_W-1:0]         up_addr_i,
  input  logic [LINE_W-1:0]         up_wdata_i,
  output logic                      up_ready_o,
  output logic [LINE_W-1:0]         up_rdata_o,
  output logic                      mem_valid_o,
  output logic                      mem_rw_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic [LINE_W-1:0]         mem_wdata_o,
  input  logic                      mem_ready_i,
  input  logic [LINE_W-1:0]         mem_rdata_i,
  input  logic                      flush_i,
  output logic                      flush_done_o,
  output logic [$clog2(WB_DEPTH):0] wb_count_o,
  output logic [31:0]               fwd_count_o
);

  localparam int TAG_W = ADDR_W - OFF_W;
  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WB_DEPTH);

  typedef enum logic [1:0] {IDLE, RD_MEM, WB_MEM, RESP} state_e;

  state_e              state_q, state_d;
  logic [WB_DEPTH-1:0] ent_vld_q, ent_vld_d;
  logic [TAG_W-1:0]    ent_tag_q  [WB_DEPTH];
  logic [TAG_W-1:0]    ent_tag_d  [WB_DEPTH];
  logic [LINE_W-1:0]   ent_line_q [WB_DEPTH];
  logic [LINE_W-1:0]   ent_line_d [WB_DEPTH];
  logic [PTR_W-1:0]    head_q, head_d;
  logic [PTR_W-1:0]    tail_q, tail_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                up_ready_q, up_ready_d;
  logic [LINE_W-1:0]   up_rdata_q, up_rdata_d;
  logic                mem_valid_q, mem_valid_d;
  logic                mem_rw_q, mem_rw_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [31:0]         fwd_cnt_q, fwd_cnt_d;

  logic [TAG_W-1:0]    up_tag;
  logic                accept;
  logic                hit;
  logic [PTR_W-1:0]    hit_idx;
  logic                unused_off;

  assign up_tag     = up_addr_i[ADDR_W-1:OFF_W];
  assign unused_off = ^up_addr_i[OFF_W-1:0];
  assign accept     = up_valid_i && !flush_i;

  // Coalescing keeps tags unique, so at most one entry can match.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (!hit && ent_vld_q[i] && ent_tag_q[i] == up_tag) begin
        hit     = 1'b1;
        hit_idx = PTR_W'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ent_vld_d   = ent_vld_q;
    ent_tag_d   = ent_tag_q;
    ent_line_d  = ent_line_q;
    head_d      = head_q;
    tail_d      = tail_q;
    cnt_d       = cnt_q;
    up_ready_d  = 1'b0;
    up_rdata_d  = up_rdata_q;
    mem_valid_d = mem_valid_q;
    mem_rw_d    = mem_rw_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    fwd_cnt_d   = fwd_cnt_q;

    case (state_q)
      IDLE: begin
        if (accept && !up_rw_i && hit) begin
          up_rdata_d = ent_line_q[hit_idx];
          fwd_cnt_d  = fwd_cnt_q + 32'd1;
          up_ready_d = 1'b1;
          state_d    = RESP;
        end else if (accept && !up_rw_i) begin
          mem_valid_d = 1'b1;
          mem_rw_d    = 1'b0;
          mem_addr_d  = {up_tag, {OFF_W{1'b0}}};
          mem_wdata_d = '0;
          state_d     = RD_MEM;
        end else if (accept && hit) begin
          ent_line_d[hit_idx] = up_wdata_i;
          up_ready_d          = 1'b1;
          state_d             = RESP;
        end else if (accept && cnt_q != FULL_CNT) begin
          ent_vld_d[tail_q]  = 1'b1;
          ent_tag_d[tail_q]  = up_tag;
          ent_line_d[tail_q] = up_wdata_i;
          tail_d             = tail_q + PTR_W'(1);
          cnt_d              = cnt_q + CNT_W'(1);
          up_ready_d         = 1'b1;
          state_d            = RESP;
        end else if (cnt_q != '0) begin
          // A full-buffer write stays pending upstream and is retried after this drain.
          mem_valid_d = 1'b1;
          mem_rw_d    = 1'b1;
          mem_addr_d  = {ent_tag_q[head_q], {OFF_W{1'b0}}};
          mem_wdata_d = ent_line_q[head_q];
          state_d     = WB_MEM;
        end
      end
      RD_MEM: begin
        if (mem_ready_i) begin
          up_rdata_d  = mem_rdata_i;
          mem_valid_d = 1'b0;
          up_ready_d  = 1'b1;
          state_d     = RESP;
        end
      end
      WB_MEM: begin
        if (mem_ready_i) begin
          ent_vld_d[head_q] = 1'b0;
          head_d            = head_q + PTR_W'(1);
          cnt_d             = cnt_q - CNT_W'(1);
          mem_valid_d       = 1'b0;
          state_d           = IDLE;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ent_vld_q   <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      cnt_q       <= '0;
      up_ready_q  <= 1'b0;
      up_rdata_q  <= '0;
      mem_valid_q <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ent_vld_q   <= ent_vld_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      cnt_q       <= cnt_d;
      up_ready_q  <= up_ready_d;
      up_rdata_q  <= up_rdata_d;
      mem_valid_q <= mem_valid_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  // Entry payload is qualified by ent_vld_q, so it needs no reset.
  always_ff @(posedge clk_i) begin
    ent_tag_q  <= ent_tag_d;
    ent_line_q <= ent_line_d;
  end

  assign up_ready_o   = up_ready_q;
  assign up_rdata_o   = up_rdata_q;
  assign mem_valid_o  = mem_valid_q;
  assign mem_rw_o     = mem_rw_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign wb_count_o   = cnt_q;
  assign fwd_count_o  = fwd_cnt_q;
  assign flush_done_o = flush_i && (cnt_q == '0) && (state_q == IDLE);

endmodule

// File: tb/tb_l2_mem_scheduler.sv
// tb/tb_l2_mem_scheduler.sv - directed and randomized scoreboard bench for l2_mem_scheduler
module tb_l2_mem_scheduler;

  localparam int ADDR_W   = 32;
  localparam int LINE_W   = 128;
  localparam int OFF_W    = 4;
  localparam int WB_DEPTH = 4;
  localparam int TAG_W    = ADDR_W - OFF_W;

  logic                      clk_i = 1'b0;
  logic                      rst_i;
  logic                      up_valid_i;
  logic                      up_rw_i;
  logic [ADDR_W-1:0]         up_addr_i;
  logic [LINE_W-1:0]         up_wdata_i;
  logic                      up_ready_o;
  logic [LINE_W-1:0]         up_rdata_o;
  logic                      mem_valid_o;
  logic                      mem_rw_o;
  logic [ADDR_W-1:0]         mem_addr_o;
  logic [LINE_W-1:0]         mem_wdata_o;
  logic                      mem_ready_i;
  logic [LINE_W-1:0]         mem_rdata_i;
  logic                      flush_i;
  logic                      flush_done_o;
  logic [$clog2(WB_DEPTH):0] wb_count_o;
  logic [31:0]               fwd_count_o;

  l2_mem_scheduler #(
    .ADDR_W(ADDR_W), .LINE_W(LINE_W), .OFF_W(OFF_W), .WB_DEPTH(WB_DEPTH)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .up_valid_i(up_valid_i), .up_rw_i(up_rw_i), .up_addr_i(up_addr_i),
    .up_wdata_i(up_wdata_i), .up_ready_o(up_ready_o), .up_rdata_o(up_rdata_o),
    .mem_valid_o(mem_valid_o), .mem_rw_o(mem_rw_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
    .flush_i(flush_i), .flush_done_o(flush_done_o),
    .wb_count_o(wb_count_o), .fwd_count_o(fwd_count_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [LINE_W-1:0] got,
                          input logic [LINE_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural view: last line written per tag, memory contents, tags still buffered.
  logic [LINE_W-1:0] shadow  [logic [TAG_W-1:0]];
  logic [LINE_W-1:0] backing [logic [TAG_W-1:0]];
  bit                pending [logic [TAG_W-1:0]];
  int                fwd_exp = 0;
  int                n_mem_rd = 0;
  int                wbc_min = 99;

  typedef struct {
    bit                rw;
    logic [ADDR_W-1:0] addr;
    int                start;
    int                done;
  } mem_ev_t;
  mem_ev_t mlog[$];

  function automatic logic [LINE_W-1:0] init_line(input logic [TAG_W-1:0] t);
    logic [31:0] w;
    w = {t, 4'h9} ^ 32'h5A5A_3C3C;
    return {w, ~w, w + 32'd7, w ^ 32'hFFFF_0000};
  endfunction

  function automatic logic [LINE_W-1:0] exp_line(input logic [TAG_W-1:0] t);
    return shadow.exists(t) ? shadow[t] : init_line(t);
  endfunction

  function automatic logic [LINE_W-1:0] mem_line(input logic [TAG_W-1:0] t);
    return backing.exists(t) ? backing[t] : init_line(t);
  endfunction

  int mem_lat  = 2;
  bit mem_rand = 1'b0;

  // Memory responder: pulses mem_ready_i a fixed or random number of cycles after a request appears.
  initial begin
    bit                busy;
    int                wait_left;
    int                start_c;
    logic [TAG_W-1:0]  t;
    busy = 1'b0; wait_left = 0; start_c = 0;
    mem_ready_i = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk_i);
      mem_ready_i = 1'b0;
      if (int'(wb_count_o) < wbc_min) wbc_min = int'(wb_count_o);
      if (!mem_valid_o) begin
        busy = 1'b0;
      end else if (!busy) begin
        busy      = 1'b1;
        start_c   = cyc;
        wait_left = (mem_rand ? int'($urandom_range(4, 1)) : mem_lat) - 1;
        if (!mem_rw_o) begin
          n_mem_rd++;
          t = mem_addr_o[ADDR_W-1:OFF_W];
          check_eq("rd_tag_not_buffered", pending.exists(t), 0);
        end
      end else if (wait_left > 0) begin
        wait_left--;
      end else begin
        t = mem_addr_o[ADDR_W-1:OFF_W];
        check_eq("mem_addr_aligned", mem_addr_o[OFF_W-1:0], 0);
        if (mem_rw_o) begin
          check_eq("wb_data", mem_wdata_o, exp_line(t));
          backing[t] = mem_wdata_o;
          pending.delete(t);
        end else begin
          mem_rdata_i = mem_line(t);
        end
        mem_ready_i = 1'b1;
        mlog.push_back('{rw: mem_rw_o, addr: mem_addr_o, start: start_c, done: cyc});
        busy = 1'b0;
      end
    end
  end

  task automatic do_req(input bit rw, input logic [ADDR_W-1:0] addr,
                        input logic [LINE_W-1:0] wd,
                        output logic [LINE_W-1:0] rd, output int lat);
    int               c0;
    int               rd0;
    bit               got;
    logic [TAG_W-1:0] t;
    t   = addr[ADDR_W-1:OFF_W];
    c0  = cyc;
    rd0 = n_mem_rd;
    got = 1'b0;
    lat = -1;
    rd  = '0;
    up_valid_i = 1'b1;
    up_rw_i    = rw;
    up_addr_i  = addr;
    up_wdata_i = wd;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk_i);
      if (up_ready_o) begin
        got = 1'b1;
        lat = cyc - c0;
        rd  = up_rdata_o;
      end
    end
    up_valid_i = 1'b0;
    check_eq("req_done", got, 1);
    if (got) begin
      if (rw) begin
        shadow[t]  = wd;
        pending[t] = 1'b1;
      end else begin
        check_eq("rd_data", rd, exp_line(t));
        if (n_mem_rd == rd0) begin
          fwd_exp++;
          check_eq("fwd_only_if_buffered", pending.exists(t), 1);
        end
      end
      check_eq("wb_count", wb_count_o, pending.num());
      check_eq("fwd_count", fwd_count_o, fwd_exp);
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    flush_i = 1'b1;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk_i);
      if (flush_done_o) ok = 1'b1;
    end
    flush_i = 1'b0;
    check_eq("flush_done", ok, 1);
    check_eq("flush_empty", wb_count_o, 0);
    check_eq("flush_model_empty", pending.num(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [LINE_W-1:0] rd;
  logic [LINE_W-1:0] wd;
  logic [ADDR_W-1:0] addr;
  logic [TAG_W-1:0]  rt;
  int                lat;
  int                c0;
  int                cnt;
  int                done_c;
  bit                seen;
  bit                rw;

  initial begin
    rst_i = 1'b1; up_valid_i = 1'b0; up_rw_i = 1'b0; up_addr_i = '0;
    up_wdata_i = '0; flush_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check_eq("rst_up_ready", up_ready_o, 0);
    check_eq("rst_mem_valid", mem_valid_o, 0);
    check_eq("rst_wb_count", wb_count_o, 0);
    check_eq("rst_fwd_count", fwd_count_o, 0);
    check_eq("rst_flush_done", flush_done_o, 0);
    rst_i = 1'b0;

    // Buffered write then forwarded read of the same line.
    do_req(1'b1, 32'h100, 128'h1111_0000_AAAA_5555_1111_0000_AAAA_5555, rd, lat);
    check_eq("t1_wr_lat", lat, 1);
    do_req(1'b0, 32'h104, '0, rd, lat);
    check_eq("t1_rd_lat", lat, 2);
    check_eq("t1_rd_data", rd, 128'h1111_0000_AAAA_5555_1111_0000_AAAA_5555);
    check_eq("t1_no_mem_rd", n_mem_rd, 0);
    check_eq("t1_fwd", fwd_count_o, 1);

    // Miss read with a 3-cycle memory.
    drain();
    mem_lat = 3;
    mlog.delete();
    c0 = cyc;
    do_req(1'b0, 32'h200, '0, rd, lat);
    check_eq("t2_data", rd, init_line(28'h20));
    check_eq("t2_lat", lat, 5);
    check_eq("t2_nmem", mlog.size(), 1);
    if (mlog.size() >= 1) begin
      check_eq("t2_rw", mlog[0].rw, 0);
      check_eq("t2_addr", mlog[0].addr, 32'h200);
      check_eq("t2_start", mlog[0].start, c0 + 1);
      check_eq("t2_ready_follow", c0 + lat, mlog[0].done + 1);
    end

    // Coalescing writes to one line.
    drain();
    mlog.delete();
    do_req(1'b1, 32'h300, 128'h3333, rd, lat);
    do_req(1'b1, 32'h308, 128'h4444_4444, rd, lat);
    check_eq("t3_count", wb_count_o, 1);
    drain();
    cnt = 0;
    foreach (mlog[i]) if (mlog[i].rw && mlog[i].addr == 32'h300) cnt++;
    check_eq("t3_single_wb", cnt, 1);
    check_eq("t3_mem", mem_line(28'h30), 128'h4444_4444);

    // Full buffer forces a head drain before the fifth write is taken.
    drain();
    mlog.delete();
    for (int i = 0; i < 4; i++)
      do_req(1'b1, 32'h400 + 32'(i * 16), 128'(i + 32'hC0DE_0000), rd, lat);
    check_eq("t4_full", wb_count_o, 4);
    wbc_min = 99;
    do_req(1'b1, 32'h440, 128'hF1F7, rd, lat);
    check_eq("t4_min_count", wbc_min, 3);
    check_eq("t4_after", wb_count_o, 4);
    check_eq("t4_nmem", mlog.size(), 1);
    if (mlog.size() >= 1) begin
      check_eq("t4_rw", mlog[0].rw, 1);
      check_eq("t4_addr", mlog[0].addr, 32'h400);
    end

    // Read miss bypasses buffered writebacks.
    drain();
    mlog.delete();
    do_req(1'b1, 32'h600, 128'h6060, rd, lat);
    do_req(1'b1, 32'h610, 128'h6161, rd, lat);
    do_req(1'b0, 32'h500, '0, rd, lat);
    check_eq("t5_nmem_pos", mlog.size() >= 1, 1);
    if (mlog.size() >= 1) begin
      check_eq("t5_first_rw", mlog[0].rw, 0);
      check_eq("t5_first_addr", mlog[0].addr, 32'h500);
    end

    // Flush with three entries while an upstream write is held.
    drain();
    mlog.delete();
    for (int i = 0; i < 3; i++)
      do_req(1'b1, 32'h700 + 32'(i * 16), 128'(i + 32'h7700), rd, lat);
    flush_i = 1'b1;
    up_valid_i = 1'b1; up_rw_i = 1'b1; up_addr_i = 32'h730; up_wdata_i = 128'h7373;
    seen = 1'b0;
    done_c = -1;
    for (int i = 0; i < 200 && done_c < 0; i++) begin
      @(negedge clk_i);
      if (up_ready_o) seen = 1'b1;
      if (flush_done_o) done_c = cyc;
    end
    repeat (3) begin
      @(negedge clk_i);
      if (up_ready_o) seen = 1'b1;
    end
    check_eq("t6_blocked", seen, 0);
    check_eq("t6_nwr", mlog.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < mlog.size()) begin
        check_eq("t6_order_addr", mlog[i].addr, 32'h700 + 32'(i * 16));
        check_eq("t6_order_rw", mlog[i].rw, 1);
      end
    end
    if (mlog.size() >= 3) check_eq("t6_done_cyc", done_c, mlog[2].done + 1);
    flush_i = 1'b0;
    c0 = cyc;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_i);
      if (up_ready_o) seen = 1'b1;
    end
    up_valid_i = 1'b0;
    check_eq("t6_released", seen, 1);
    check_eq("t6_release_lat", cyc - c0, 1);
    shadow[28'h73]  = 128'h7373;
    pending[28'h73] = 1'b1;

    // Reset while a memory read is outstanding.
    drain();
    mem_lat = 4;
    up_valid_i = 1'b1; up_rw_i = 1'b0; up_addr_i = 32'h800;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk_i);
      if (mem_valid_o) seen = 1'b1;
    end
    check_eq("t7_in_rd_mem", seen, 1);
    rst_i = 1'b1;
    up_valid_i = 1'b0;
    @(negedge clk_i);
    check_eq("t7_mem_valid", mem_valid_o, 0);
    check_eq("t7_up_ready", up_ready_o, 0);
    check_eq("t7_wb_count", wb_count_o, 0);
    check_eq("t7_fwd_count", fwd_count_o, 0);
    rst_i = 1'b0;
    fwd_exp = 0;

    // Randomized traffic over a small tag pool so hits, coalescing and full-buffer cases recur.
    mem_rand = 1'b1;
    repeat (250) begin
      rt   = 28'h1000 + 28'($urandom_range(7, 0));
      addr = {rt, 4'($urandom)};
      rw   = 1'($urandom_range(1, 0));
      wd   = {$urandom, $urandom, $urandom, $urandom};
      do_req(rw, addr, wd, rd, lat);
      repeat ($urandom_range(3, 0)) @(negedge clk_i);
      if ($urandom_range(15, 0) == 0) drain();
    end
    drain();
    foreach (shadow[k]) check_eq("final_mem", mem_line(k), shadow[k]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
